uart_cmd_rx: RTL
================

Name: uart_cmd_rx

Overview:
Receive-side command parser for the sequencer debug UART. It consumes bytes from the UART receiver (rx_byte / received) and decodes ASCII lines of the form "W<r>:<hex>" (register write) and "R<r>" (register read request). Decoded commands are issued as single-cycle strobes to the sequencer register file. It is the inbound counterpart of the hex-dump transmit path: that path prints "R<r>:XXXX\n\r", and this block parses the same textual format.

Parameters:
DP_WIDTH, 16, datapath/register width in bits; must be a multiple of 4.
NUM_NIB, DP_WIDTH/4, number of hex digits required in a write payload.
TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
i_rx_data  input  8  received byte, valid when i_rx_valid=1
i_rx_valid  input  1  one-cycle strobe per received byte
o_wr_stb  output  1  one-cycle write command strobe
o_wr_reg  output  2  register index for write/read
o_wr_data  output  DP_WIDTH  write payload
o_rd_stb  output  1  one-cycle read command strobe
o_err  output  1  one-cycle syntax/timeout error strobe
o_busy  output  1  high while a command is partially received (state != stIdle)

Behaviour:
- Reset: every output is 0; state is stIdle; the nibble counter and shift register are 0.
- Bytes are processed only on cycles where i_rx_valid=1. There is no backpressure.
- Character classes:
  - hex digit = '0'-'9', 'A'-'F', 'a'-'f'.
  - reg digit = '0'-'3'.
  - terminator = 0x0D or 0x0A.
- States and transitions:
  - stIdle: 'W'/'w' -> stWReg. 'R'/'r' -> stRReg. Terminator or space -> stay, no error. Anything else -> stErr with o_err.
  - stWReg: reg digit -> latch index, go to stColon. Otherwise -> stErr.
  - stColon: ':' -> clear shift register and nibble count, go to stData. Otherwise -> stErr.
  - stData: hex digit -> shift register <= {shift[DP_WIDTH-5:0], nib}, count+1. When count reaches NUM_NIB -> stTerm. Non-hex -> stErr, including a terminator arriving before NUM_NIB digits.
  - stTerm: terminator -> o_wr_stb, go to stIdle. Anything else (e.g. a 5th digit) -> stErr.
  - stRReg: reg digit -> latch index, go to stRTerm. Otherwise -> stErr.
  - stRTerm: terminator -> o_rd_stb, go to stIdle. Otherwise -> stErr.
  - stErr: discard bytes; terminator -> stIdle (no strobe). o_err pulses only on entry into stErr, never again while in it.
- Latency: o_wr_stb, o_rd_stb and o_err are registered and assert on the cycle after the deciding byte's i_rx_valid cycle. Each lasts exactly one cycle.
- o_wr_reg and o_wr_data update in the same cycle as the strobe and hold until the next successful command. o_rd_stb updates only o_wr_reg; o_wr_data is unchanged.
- A partially received payload never appears on o_wr_data.
- Reset mid-command: return to stIdle and discard the partial command; no strobe is issued.
- The block is purely byte-driven, so simultaneous events cannot occur.

Optional Feature:
UART_CMD_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYC+1) clears on every i_rx_valid and whenever state = stIdle.
  - It increments otherwise and saturates.
  - Reaching TIMEOUT_CYC in any non-idle state forces stIdle on the next cycle.
  - o_err pulses once, unless the state was already stErr, in which case the block returns silently.
- Undefined: no counter exists; a partial command waits indefinitely.

Decomposition:
- Shared package/include (alongside seq_definitions.v):
  - state encodings (3-bit localparams).
  - ASCII constants: CR, LF, ':', 'W', 'R'.
  - function fnASCII2Nib (returns the valid flag and the 4-bit value).
- Natural sub-module: uart_hex_decode, a combinational ASCII classifier with outputs is_hex, nib[3:0], is_reg, is_term. It is kept small and is reused by any future parser.
- Top-level integration instantiates uart_cmd_rx on the o_rx_data/o_rx_valid outputs of uart_top.

Test Plan:
1. Bytes "W2:1A3F\r" -> one o_wr_stb pulse one cycle after '\r', o_wr_reg=2, o_wr_data=16'h1A3F, o_err never high.
2. Bytes "r1\n" -> one o_rd_stb pulse, o_wr_reg=1, o_wr_data unchanged from test 1.
3. Bytes "W0:12G4\r" then "w3:beef\n" -> o_err pulse once after 'G', no strobe on the first '\r'; second command gives o_wr_stb, reg=3, data=16'hBEEF.
4. Bytes "W1:12345\r" -> o_err after '5', no o_wr_stb. Bytes "W1:12\r" -> o_err after '\r'. After each, o_busy=0 following the terminator or the error-line terminator.
5. Bytes "W2:AB", assert rst for 1 cycle, then "R0\r" -> no o_wr_stb; o_rd_stb with reg=0; outputs are 0 during reset.
6. (UART_CMD_TIMEOUT_EN, TIMEOUT_CYC=50) Bytes "W1:", idle 60 cycles -> o_err once at cycle 50, o_busy falls. Then "W1:0001\r" -> o_wr_stb, data=16'h0001.

Source files
------------

// File: rtl/uart_cmd_rx_pkg.sv
// rtl/uart_cmd_rx_pkg.sv - shared definitions for the debug UART command parser
//
// Purpose : parser state encoding, ASCII constants and the ASCII-to-nibble
//           helper shared by uart_hex_decode and uart_cmd_rx.
// Ports   : none (package).

package uart_cmd_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREG  = 3'd1,
    ST_COLON = 3'd2,
    ST_DATA  = 3'd3,
    ST_TERM  = 3'd4,
    ST_RREG  = 3'd5,
    ST_RTERM = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Returns {valid, nib}. Upper and lower case hex letters share the same low
  // nibble offset ('A'=0x41, 'a'=0x61), so one add covers both.
  function automatic logic [4:0] fn_ascii2nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_hex_decode.sv
// rtl/uart_hex_decode.sv - combinational ASCII character classifier
//
// Purpose : classifies one received byte for the command parsers.
// Ports   : i_char     in  8  byte to classify
//           o_is_hex   out 1  '0'-'9', 'A'-'F', 'a'-'f'
//           o_nib      out 4  hex value (0 when not a hex digit)
//           o_is_reg   out 1  register digit '0'-'3'
//           o_is_term  out 1  line terminator CR or LF

module uart_hex_decode
  import uart_cmd_rx_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_hex,
  output logic [3:0] o_nib,
  output logic       o_is_reg,
  output logic       o_is_term
);

  assign {o_is_hex, o_nib} = fn_ascii2nib(i_char);
  assign o_is_reg  = (i_char >= 8'h30) && (i_char <= 8'h33);
  assign o_is_term = (i_char == ASCII_CR) || (i_char == ASCII_LF);

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - debug UART command line parser ("W<r>:<hex>" / "R<r>")
//
// Purpose : decodes ASCII write/read command lines from the UART receiver into
//           single-cycle strobes for the sequencer register file.
// Ports   : clk         in  1         clock
//           rst         in  1         synchronous active-high reset
//           i_rx_data   in  8         received byte, valid with i_rx_valid
//           i_rx_valid  in  1         one-cycle strobe per byte
//           o_wr_stb    out 1         write command strobe
//           o_wr_reg    out 2         register index of last write/read
//           o_wr_data   out DP_WIDTH  payload of last write
//           o_rd_stb    out 1         read command strobe
//           o_err       out 1         syntax/timeout error strobe
//           o_busy      out 1         command partially received
// Option  : UART_CMD_TIMEOUT_EN adds an inter-byte timeout of TIMEOUT_CYC clocks.

module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int DP_WIDTH    = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_wr_stb,
  output logic [1:0]          o_wr_reg,
  output logic [DP_WIDTH-1:0] o_wr_data,
  output logic                o_rd_stb,
  output logic                o_err,
  output logic                o_busy
);

  localparam int NUM_NIB = DP_WIDTH / 4;
  localparam int CNT_W   = $clog2(NUM_NIB + 1);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

  // The shift register splice below needs at least two nibbles.
  if ((DP_WIDTH % 4) != 0 || DP_WIDTH < 8) begin : g_bad_width
    $error("uart_cmd_rx: DP_WIDTH must be a multiple of 4 and at least 8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("uart_cmd_rx: TIMEOUT_CYC must be at least 1");
  end

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [DP_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_stb_q, wr_stb_d;
  logic                 rd_stb_q, rd_stb_d;
  logic                 err_q, err_d;
  logic [1:0]           wr_reg_q, wr_reg_d;
  logic [DP_WIDTH-1:0]  wr_data_q, wr_data_d;

  logic       is_hex;
  logic [3:0] nib;
  logic       is_reg;
  logic       is_term;
  logic       is_w;
  logic       is_r;
  logic       is_colon;
  logic       is_space;
  logic       go_err;
  logic       timeout_hit;

  uart_hex_decode u_hex_decode (
    .i_char    (i_rx_data),
    .o_is_hex  (is_hex),
    .o_nib     (nib),
    .o_is_reg  (is_reg),
    .o_is_term (is_term)
  );

  // Setting bit 5 folds upper case onto lower case for the command letters.
  assign is_w     = (i_rx_data | 8'h20) == (ASCII_W | 8'h20);
  assign is_r     = (i_rx_data | 8'h20) == (ASCII_R | 8'h20);
  assign is_colon = (i_rx_data == ASCII_COLON);
  assign is_space = (i_rx_data == ASCII_SPACE);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  logic [TO_W-1:0] to_q, to_d;

  always_comb begin
    to_d = to_q;
    if (i_rx_valid || state_q == ST_IDLE) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + TO_W'(1);
    end
  end

  assign timeout_hit = (state_q != ST_IDLE) && (to_q == TO_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    err_d     = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    go_err    = 1'b0;

    if (i_rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (is_w) begin
            state_d = ST_WREG;
          end else if (is_r) begin
            state_d = ST_RREG;
          end else if (!(is_term || is_space)) begin
            go_err = 1'b1;
          end
        end
        ST_WREG: begin
          if (is_reg) begin
            idx_d   = i_rx_data[1:0];
            state_d = ST_COLON;
          end else begin
            go_err = 1'b1;
          end
        end
        ST_COLON: begin
          if (is_colon) begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = ST_DATA;
          end else begin
            go_err = 1'b1;
          end
        end
        ST_DATA: begin
          if (is_hex) begin
            shift_d = {shift_q[DP_WIDTH-5:0], nib};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_NIB) begin
              state_d = ST_TERM;
            end
          end else begin
            go_err = 1'b1;
          end
        end
        ST_TERM: begin
          // Payload reaches the outputs only here, once the line is complete.
          if (is_term) begin
            wr_stb_d  = 1'b1;
            wr_reg_d  = idx_q;
            wr_data_d = shift_q;
            state_d   = ST_IDLE;
          end else begin
            go_err = 1'b1;
          end
        end
        ST_RREG: begin
          if (is_reg) begin
            idx_d   = i_rx_data[1:0];
            state_d = ST_RTERM;
          end else begin
            go_err = 1'b1;
          end
        end
        ST_RTERM: begin
          if (is_term) begin
            rd_stb_d = 1'b1;
            wr_reg_d = idx_q;
            state_d  = ST_IDLE;
          end else begin
            go_err = 1'b1;
          end
        end
        ST_ERR: begin
          // Swallow the rest of the bad line; the error was already flagged.
          if (is_term) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (go_err) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end

    // A timeout abandons the line; a byte landing on that same cycle is dropped
    // with it. Leaving stErr this way is silent since the error was reported.
    if (timeout_hit) begin
      state_d  = ST_IDLE;
      wr_stb_d = 1'b0;
      rd_stb_d = 1'b0;
      err_d    = (state_q != ST_ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      shift_q   <= '0;
      cnt_q     <= '0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      err_q     <= 1'b0;
      wr_reg_q  <= 2'd0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      err_q     <= err_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_wr_stb  = wr_stb_q;
  assign o_rd_stb  = rd_stb_q;
  assign o_err     = err_q;
  assign o_wr_reg  = wr_reg_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule
